si5340_i2c_responder: RTL
=========================

Name: si5340_i2c_responder

Overview:
- Synthesizable I2C target that models the Si5340 register interface at 7-bit address 0x74.
- Pairs with the config loader's I2C initiator in loopback and simulation benches; can also stand in for the device on FPGA-only builds.
- Oversamples SCL/SDA on the system clock. Decodes START, STOP, address, register pointer and data bytes, then issues 24-bit {page, reg, data} write records matching the config memory word format.
- Serves reads from an external register file.

Parameters:
- SLAVE_ADDR, 7'b111_0100, 7-bit target address that is ACKed.
- FILTER_LEN, 3, consecutive identical synchronized samples required to accept a new SCL/SDA level (glitch filter).
- PAGE_REG, 8'h01, register offset whose write also updates the internal page register.

Ports:
- clk_i, in, 1, system clock (125 MHz nominal).
- arstn_i, in, 1, asynchronous active-low reset.
- scl_i, in, 1, raw SCL from pad.
- sda_i, in, 1, raw SDA from pad.
- sda_oe_o, in/out: out, 1, 1 = pull SDA low (open-drain); 0 = release.
- wr_valid_o, out, 1, one-cycle strobe: data byte written.
- wr_data_o, out, 24, {page[7:0], reg[7:0], data[7:0]} of the write; held until the next strobe.
- rd_addr_o, out, 16, {page, reg_ptr} of the byte about to be transmitted.
- rd_data_i, in, 8, register-file read data for rd_addr_o; combinational or registered, must be valid 2 clk after rd_addr_o changes.
- busy_o, out, 1, high from accepted START to STOP.

Behaviour:
- Input conditioning:
  - 2-flop synchronizer per line, then FILTER_LEN-deep filter.
  - Edge and START/STOP detection run on the filtered levels only.
  - Filtered levels reset to 1.
- Conditions:
  - START = filtered SDA 1->0 while filtered SCL is 1.
  - STOP = filtered SDA 0->1 while filtered SCL is 1.
  - Both are recognised in any state, including mid-byte, and take priority over bit sampling in the same cycle.
- Bit timing:
  - SDA is sampled on the filtered SCL rising edge, MSB first.
  - sda_oe_o changes only on the filtered SCL falling edge.
- FSM states: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
  - IDLE -START-> ADDR. A repeated START from any state also -> ADDR.
  - ADDR, 8 bits: addr[6:0] == SLAVE_ADDR -> ADDR_ACK, else -> IGNORE (sda_oe_o stays 0).
  - ADDR_ACK: drive ACK for one SCL period.
    - R/W=0 -> REG.
    - R/W=1 -> RDATA, first read byte from the current {page, reg_ptr}.
  - REG, 8 bits: load reg_ptr -> REG_ACK -> WDATA.
  - WDATA, 8 bits:
    - On the 8th rising edge, wr_valid_o pulses 1 clk later with {page, reg_ptr, byte}.
    - If reg_ptr == PAGE_REG, page <= byte; the strobe carries the old page.
    - Then -> WDATA_ACK; reg_ptr increments at the ACK falling edge; -> WDATA.
  - RDATA:
    - rd_addr_o = {page, reg_ptr}.
    - rd_data_i is loaded into the shift register on the SCL falling edge that ends the previous ACK.
    - Shift out MSB first, driving sda_oe_o = ~bit.
    - After 8 bits, release SDA -> RDATA_ACK.
  - RDATA_ACK: sample the initiator bit on the rising edge.
    - ACK (0): reg_ptr++ and -> RDATA.
    - NACK (1): -> IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
  - STOP in any state -> IDLE with SDA released and busy_o = 0.
- Pointer rules:
  - reg_ptr wraps 0xFF -> 0x00; page is unchanged on wrap.
  - reg_ptr and page persist across STOP and repeated START. Set-address-then-read is supported.
- Reset, asynchronous, any time including mid-transfer:
  - State = IDLE.
  - sda_oe_o = 0, wr_valid_o = 0, wr_data_o = 0, rd_addr_o = 0, busy_o = 0.
  - page = 0, reg_ptr = 0, bit counter = 0.
- A START inside an ACK slot releases SDA immediately, before the next falling edge.

Test Plan:
- Write to 0x74: reg 0x01, data 0x0B, then STOP -> ACK on all 3 bytes; one wr_valid_o with wr_data_o = 0x00_01_0B; page becomes 0x0B.
- Burst write to 0x74: reg 0xFE, data 0x11, 0x22, 0x33 -> three strobes 0x0B_FE_11, 0x0B_FF_22, 0x0B_00_33 (pointer wrap, page unchanged).
- Address 0x75 write, 2 bytes -> SDA never driven low; no wr_valid_o; busy_o drops on STOP.
- Read sequence: write reg 0x10, repeated START, read 2 bytes with ACK then NACK.
  - rd_addr_o = 0x0B10 then 0x0B11.
  - Bus carries the rd_data_i values.
  - SDA released after NACK.
- Glitch test: 2-clk SCL and SDA pulses (< FILTER_LEN) during a byte -> no bit shift, no START/STOP detected; transfer completes correctly.
- Assert arstn_i during WDATA bit 4, release, then a full write -> sda_oe_o = 0 immediately; no strobe for the aborted byte; page = 0; next transaction behaves normally.

Source files
------------

// File: rtl/si5340_i2c_responder.sv
// si5340_i2c_responder: filtered I2C target at SLAVE_ADDR emitting {page,reg,data} write strobes and serving reads; ports clk_i/arstn_i, scl_i/sda_i pads, sda_oe_o pull-low, wr_valid_o/wr_data_o writes, rd_addr_o/rd_data_i reads, busy_o
module si5340_i2c_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'b111_0100,
  parameter int         FILTER_LEN = 3,
  parameter logic [7:0] PAGE_REG   = 8'h01
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe_o,
  output logic        wr_valid_o,
  output logic [23:0] wr_data_o,
  output logic [15:0] rd_addr_o,
  input  logic [7:0]  rd_data_i,
  output logic        busy_o
);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;
  state_t state_q, state_d;
  logic [1:0] scl_s, sda_s;
  logic [FILTER_LEN-1:0] scl_h, sda_h;
  logic scl_f, sda_f, scl_p, sda_p;
  logic scl_rise, scl_fall, start, stop;
  logic [3:0] cnt;
  logic [7:0] sr, reg_ptr, page, byte_in;
  always_ff @(posedge clk_i or negedge arstn_i)
    if (!arstn_i) begin
      {scl_s, sda_s, scl_h, sda_h} <= '1;
      {scl_f, sda_f, scl_p, sda_p} <= '1;
    end else begin
      scl_s <= {scl_s[0], scl_i};
      sda_s <= {sda_s[0], sda_i};
      scl_h <= {scl_h[FILTER_LEN-2:0], scl_s[1]};
      sda_h <= {sda_h[FILTER_LEN-2:0], sda_s[1]};
      scl_f <= &scl_h ? 1'b1 : ~|scl_h ? 1'b0 : scl_f;
      sda_f <= &sda_h ? 1'b1 : ~|sda_h ? 1'b0 : sda_f;
      scl_p <= scl_f;
      sda_p <= sda_f;
    end
  assign scl_rise  = scl_f & ~scl_p;
  assign scl_fall  = ~scl_f & scl_p;
  assign start     = scl_f & scl_p & sda_p & ~sda_f;
  assign stop      = scl_f & scl_p & ~sda_p & sda_f;
  assign byte_in   = {sr[6:0], sda_f};
  assign rd_addr_o = {page, reg_ptr};
  always_ff @(posedge clk_i or negedge arstn_i)
    if (!arstn_i) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (start) state_d = ADDR;
    else if (stop) state_d = IDLE;
    else if (scl_rise && state_q == RDATA_ACK && sda_f) state_d = IGNORE;
    else if (scl_fall)
      case (state_q)
        ADDR:      if (cnt == 4'd8) state_d = sr[7:1] == SLAVE_ADDR ? ADDR_ACK : IGNORE;
        ADDR_ACK:  state_d = sr[0] ? RDATA : REG;
        REG:       if (cnt == 4'd8) state_d = REG_ACK;
        REG_ACK:   state_d = WDATA;
        WDATA:     if (cnt == 4'd8) state_d = WDATA_ACK;
        WDATA_ACK: state_d = WDATA;
        RDATA:     if (cnt == 4'd8) state_d = RDATA_ACK;
        RDATA_ACK: state_d = RDATA;
        default:   state_d = state_q;
      endcase
  end
  always_ff @(posedge clk_i or negedge arstn_i)
    if (!arstn_i) begin
      cnt        <= '0;
      sr         <= '0;
      reg_ptr    <= '0;
      page       <= '0;
      sda_oe_o   <= 1'b0;
      wr_valid_o <= 1'b0;
      wr_data_o  <= '0;
      busy_o     <= 1'b0;
    end else begin
      wr_valid_o <= 1'b0;
      if (start || stop) begin
        cnt      <= '0;
        sda_oe_o <= 1'b0;
        busy_o   <= start;
      end else if (scl_rise) begin
        if (state_q inside {ADDR, REG, WDATA, RDATA}) cnt <= cnt + 4'd1;
        if (state_q inside {ADDR, REG, WDATA}) sr <= byte_in;
        if (state_q == REG && cnt == 4'd7) reg_ptr <= byte_in;
        if (state_q == RDATA_ACK && !sda_f) reg_ptr <= reg_ptr + 8'd1;
        if (state_q == WDATA && cnt == 4'd7) begin
          wr_valid_o <= 1'b1;
          wr_data_o  <= {page, reg_ptr, byte_in};
          if (reg_ptr == PAGE_REG) page <= byte_in;
        end
      end else if (scl_fall) begin
        if (state_d != state_q) cnt <= '0;
        if (state_q == WDATA_ACK) reg_ptr <= reg_ptr + 8'd1;
        if (state_d == RDATA) sr <= state_q == RDATA ? {sr[6:0], 1'b0} : rd_data_i;
        sda_oe_o <= state_d inside {ADDR_ACK, REG_ACK, WDATA_ACK} ||
                    (state_d == RDATA && (state_q == RDATA ? !sr[6] : !rd_data_i[7]));
      end
    end
endmodule
